// File: rtl/adsr_pkg.sv
// adsr_pkg: shared types and constants for the ADSR envelope generator.
// State encoding and amplitude scale used by adsr_env and its helpers.
package adsr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } adsr_state_t;

    localparam int          AW      = 32;
    localparam logic [31:0] AMP_MAX = 32'h8000_0000;
    localparam logic [31:0] SUS_INF = 32'hFFFF_FFFF;

endpackage

// File: rtl/adsr_sat_step.sv
// adsr_sat_step: one linear ramp step of the amplitude, clamped to a bound.
// Compares are done on the 33-bit result so no wrap can reach the caller.
module adsr_sat_step
    import adsr_pkg::*;
(
    input  logic        sub,
    input  logic [31:0] amp,
    input  logic [31:0] step,
    input  logic [31:0] bound,
    output logic [31:0] result,
    output logic        hit
);

    logic [32:0] sum;
    logic [32:0] diff;

    // Extended add/sub, clamp to bound when reached or when the step is zero
    always_comb begin
        sum  = {1'b0, amp} + {1'b0, step};
        diff = {1'b0, amp} - {1'b0, step};
        if (sub) begin
            hit = (step == '0) ||
                  ($signed(diff) <= $signed({1'b0, bound}));
        end else begin
            hit = (step == '0) || (sum >= {1'b0, bound});
        end
        if (hit) begin
            result = bound;
        end else if (sub) begin
            result = diff[31:0];
        end else begin
            result = sum[31:0];
        end
    end

endmodule

// File: rtl/adsr_env.sv
// adsr_env: linear attack/decay/sustain/release envelope for one voice.
// 32-bit amplitude accumulator, env output is its top 15 bits in Q2.14.
module adsr_env
    import adsr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] attack_step,
    input  logic [31:0] decay_step,
    input  logic [31:0] sus_level,
    input  logic [31:0] sus_time,
    input  logic [31:0] release_step,
    output logic [15:0] env,
    output logic        adsr_idle
);

    adsr_state_t state;
    adsr_state_t state_nxt;
    logic [31:0] amp_reg;
    logic [31:0] amp_nxt;
    logic [31:0] sus_cnt;
    logic [31:0] cnt_nxt;
    logic [31:0] lvl;
    logic        st_sub;
    logic [31:0] st_step;
    logic [31:0] st_bound;
    logic [31:0] st_result;
    logic        st_hit;

    assign lvl = (sus_level > AMP_MAX) ? AMP_MAX : sus_level;

    // Pick the ramp direction, step and target for the current phase
    always_comb begin
        st_sub   = 1'b1;
        st_step  = release_step;
        st_bound = '0;
        unique case (state)
            ATTACK: begin
                st_sub   = 1'b0;
                st_step  = attack_step;
                st_bound = AMP_MAX;
            end
            DECAY: begin
                st_step  = decay_step;
                st_bound = lvl;
            end
            default: begin
                st_step  = release_step;
                st_bound = '0;
            end
        endcase
    end

    adsr_sat_step u_step (
        .sub    (st_sub),
        .amp    (amp_reg),
        .step   (st_step),
        .bound  (st_bound),
        .result (st_result),
        .hit    (st_hit)
    );

    // State, amplitude and sustain counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            amp_reg <= '0;
            sus_cnt <= '0;
        end else begin
            state   <= state_nxt;
            amp_reg <= amp_nxt;
            sus_cnt <= cnt_nxt;
        end
    end

    // Next state: start retriggers from the current amplitude, stop forces release
    always_comb begin
        state_nxt = state;
        amp_nxt   = amp_reg;
        cnt_nxt   = sus_cnt;
        if (start) begin
            state_nxt = ATTACK;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    amp_nxt = '0;
                end
                ATTACK: begin
                    if (stop) begin
                        state_nxt = RELEASE;
                    end else begin
                        amp_nxt = st_result;
                        if (st_hit) state_nxt = DECAY;
                    end
                end
                DECAY: begin
                    if (stop) begin
                        state_nxt = RELEASE;
                    end else begin
                        amp_nxt = st_result;
                        if (st_hit) begin
                            state_nxt = SUSTAIN;
                            cnt_nxt   = '0;
                        end
                    end
                end
                SUSTAIN: begin
                    if (stop) begin
                        state_nxt = RELEASE;
                    end else begin
                        amp_nxt = lvl;
                        if (sus_time != SUS_INF) begin
                            if (sus_time == '0 ||
                                sus_cnt == sus_time - 32'd1) begin
                                state_nxt = RELEASE;
                            end else begin
                                cnt_nxt = sus_cnt + 32'd1;
                            end
                        end
                    end
                end
                RELEASE: begin
                    amp_nxt = st_result;
                    if (st_hit) state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    amp_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs decoded straight from registers
    always_comb begin
        env       = {1'b0, amp_reg[31:17]};
        adsr_idle = (state == IDLE);
    end

endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: directed self-checking bench for adsr_env.
// Each task drives one scenario and checks env/adsr_idle against hand values.
module tb_adsr_env;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] attack_step = '0;
    logic [31:0] decay_step = '0;
    logic [31:0] sus_level = '0;
    logic [31:0] sus_time = '0;
    logic [31:0] release_step = '0;
    logic [15:0] env;
    logic        adsr_idle;

    int checks = 0;
    int errors = 0;

    adsr_env dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .attack_step  (attack_step),
        .decay_step   (decay_step),
        .sus_level    (sus_level),
        .sus_time     (sus_time),
        .release_step (release_step),
        .env          (env),
        .adsr_idle    (adsr_idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (env !== 16'h0000 || adsr_idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_init env=%h idle=%b exp 0000/1", env, adsr_idle);
        end
        attack_step = 32'h2000_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (env !== 16'h1000 || adsr_idle !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre env=%h idle=%b exp 1000/0", env, adsr_idle);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (env !== 16'h0000 || adsr_idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid env=%h idle=%b exp 0000/1", env, adsr_idle);
        end
        tick();
        checks++;
        if (env !== 16'h0000 || adsr_idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_stay env=%h idle=%b exp 0000/1", env, adsr_idle);
        end
    endtask

    task automatic test_full_note();
        logic [15:0] seq [0:14];
        do_reset();
        attack_step  = 32'h2000_0000;
        decay_step   = 32'h1000_0000;
        sus_level    = 32'h4000_0000;
        sus_time     = 32'd3;
        release_step = 32'h1000_0000;
        seq = '{16'h1000, 16'h2000, 16'h3000, 16'h4000,
                16'h3800, 16'h3000, 16'h2800, 16'h2000,
                16'h2000, 16'h2000, 16'h2000,
                16'h1800, 16'h1000, 16'h0800, 16'h0000};
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (env !== 16'h0000 || adsr_idle !== 1'b0) begin
            errors++;
            $display("FAIL note_latency env=%h idle=%b exp 0000/0", env, adsr_idle);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (env !== seq[i] || adsr_idle !== (i == 14)) begin
                errors++;
                $display("FAIL note_step%0d env=%h idle=%b exp %h/%b",
                         i, env, adsr_idle, seq[i], (i == 14));
            end
        end
        tick();
        checks++;
        if (env !== 16'h0000 || adsr_idle !== 1'b1) begin
            errors++;
            $display("FAIL note_idle env=%h idle=%b exp 0000/1", env, adsr_idle);
        end
    endtask

    task automatic test_hold_and_instant();
        do_reset();
        attack_step  = 32'h0;
        decay_step   = 32'h0;
        sus_level    = 32'h2000_0000;
        sus_time     = 32'hFFFF_FFFF;
        release_step = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (env !== 16'h4000) begin
            errors++;
            $display("FAIL inst_attack env=%h exp 4000", env);
        end
        tick();
        checks++;
        if (env !== 16'h1000) begin
            errors++;
            $display("FAIL inst_decay env=%h exp 1000", env);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (env !== 16'h1000 || adsr_idle !== 1'b0) begin
            errors++;
            $display("FAIL hold env=%h idle=%b exp 1000/0", env, adsr_idle);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (env !== 16'h1000 || adsr_idle !== 1'b0) begin
            errors++;
            $display("FAIL stop_hold env=%h idle=%b exp 1000/0", env, adsr_idle);
        end
        tick();
        checks++;
        if (env !== 16'h0000 || adsr_idle !== 1'b1) begin
            errors++;
            $display("FAIL inst_release env=%h idle=%b exp 0000/1", env, adsr_idle);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (env !== 16'h0000 || adsr_idle !== 1'b1) begin
            errors++;
            $display("FAIL stop_idle env=%h idle=%b exp 0000/1", env, adsr_idle);
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        attack_step  = 32'h0;
        decay_step   = 32'h0;
        sus_level    = 32'h4000_0000;
        sus_time     = 32'd1;
        release_step = 32'h1000_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (env !== 16'h2000) begin
            errors++;
            $display("FAIL rt_rel_entry env=%h exp 2000", env);
        end
        tick();
        checks++;
        if (env !== 16'h1800) begin
            errors++;
            $display("FAIL rt_rel env=%h exp 1800", env);
        end
        attack_step = 32'h0800_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (env !== 16'h1800 || adsr_idle !== 1'b0) begin
            errors++;
            $display("FAIL rt_keep env=%h idle=%b exp 1800/0", env, adsr_idle);
        end
        tick();
        checks++;
        if (env !== 16'h1C00) begin
            errors++;
            $display("FAIL rt_rise1 env=%h exp 1c00", env);
        end
        tick();
        checks++;
        if (env !== 16'h2000) begin
            errors++;
            $display("FAIL rt_rise2 env=%h exp 2000", env);
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (env !== 16'h2000) begin
            errors++;
            $display("FAIL both_hold env=%h exp 2000", env);
        end
        tick();
        checks++;
        if (env !== 16'h2400) begin
            errors++;
            $display("FAIL both_attack env=%h exp 2400", env);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (env !== 16'h2400) begin
            errors++;
            $display("FAIL stop_attack env=%h exp 2400", env);
        end
        tick();
        checks++;
        if (env !== 16'h1C00) begin
            errors++;
            $display("FAIL stop_release env=%h exp 1c00", env);
        end
    endtask

    task automatic test_clip();
        do_reset();
        attack_step  = 32'hFFFF_FFFF;
        decay_step   = 32'h1000_0000;
        sus_level    = 32'hFFFF_FFFF;
        sus_time     = 32'hFFFF_FFFF;
        release_step = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (env !== 16'h4000) begin
            errors++;
            $display("FAIL clip_attack env=%h exp 4000", env);
        end
        tick();
        checks++;
        if (env !== 16'h4000) begin
            errors++;
            $display("FAIL clip_decay env=%h exp 4000", env);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (env !== 16'h4000 || adsr_idle !== 1'b0) begin
            errors++;
            $display("FAIL clip_sus env=%h idle=%b exp 4000/0", env, adsr_idle);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (env !== 16'h4000) begin
            errors++;
            $display("FAIL clip_retrig env=%h exp 4000", env);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
        checks++;
        if (env !== 16'h0000 || adsr_idle !== 1'b1) begin
            errors++;
            $display("FAIL clip_release env=%h idle=%b exp 0000/1", env, adsr_idle);
        end
    endtask

    initial begin
        test_reset();
        test_full_note();
        test_hold_and_instant();
        test_retrigger();
        test_clip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
